// File: rtl/seq_chunk_adder.sv
// Multi-cycle unsigned add/sub/accumulate unit that processes CHUNK bits per clock.
// It uses a registered carry between chunks and a start/ready/done handshake.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic              sat_q;
    logic [WIDTH-1:0]  opa_q;
    logic [WIDTH-1:0]  opb_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  shadow_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic [CHUNK:0]    chunkSum;
    logic              lastChunk;
    logic [WIDTH-1:0]  shadow_d;
    logic              ovf_d;
    logic [WIDTH-1:0]  result_d;

    // Operands shift right each RUN cycle, so the active chunk always sits in the low bits.
    // Finished chunks enter the shadow result from the top.
    always_comb begin
        chunkSum  = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        lastChunk = (idx_q == IDXW'(NCHUNK - 1));
        shadow_d  = (shadow_q >> CHUNK) | (WIDTH'(chunkSum[CHUNK-1:0]) << (WIDTH - CHUNK));
        ovf_d     = (mode_q == MODE_SUB) ? ~chunkSum[CHUNK] : chunkSum[CHUNK];
        result_d  = shadow_d;
        if (sat_q && ovf_d) begin
            result_d = (mode_q == MODE_SUB) ? '0 : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= MODE_ADD;
            sat_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        sat_q    <= sat;
                        opa_q    <= (mode == MODE_ACC) ? acc_q : dataa;
                        opb_q    <= (mode == MODE_SUB) ? ~datab : datab;
                        carry_q  <= (mode == MODE_SUB);
                        idx_q    <= '0;
                        shadow_q <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (mode == MODE_CLR) begin
                            state_q <= DONE;
                            sum_q   <= '0;
                            acc_q   <= '0;
                            cout_q  <= 1'b0;
                            ovf_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    opa_q    <= opa_q >> CHUNK;
                    opb_q    <= opb_q >> CHUNK;
                    carry_q  <= chunkSum[CHUNK];
                    shadow_q <= shadow_d;
                    idx_q    <= idx_q + IDXW'(1);
                    // Visible outputs change only here, never with a partial result.
                    if (lastChunk) begin
                        state_q <= DONE;
                        sum_q   <= result_d;
                        cout_q  <= chunkSum[CHUNK];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        if (mode_q == MODE_ACC) begin
                            acc_q <= result_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder at WIDTH=16, CHUNK=4.
// It uses a vector table plus hand-written back-to-back, accumulate and reset-abort sequences.
module tb_seq_chunk_adder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        sat;
    logic [15:0] dataa;
    logic [15:0] datab;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int testsRun  = 0;
    int failCount = 0;
    logic [15:0] prevSum = 16'h0000;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .sat(sat),
        .dataa(dataa), .datab(datab), .ready(ready), .busy(busy), .done(done),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge with ready=1. The latency count includes the accepting edge,
    // so a RUN op reports 5 and a clear op reports 1.
    task automatic applyStimulus(input string name, input logic [1:0] m, input logic s,
                                 input logic [15:0] a, input logic [15:0] b, input bit glitch,
                                 input logic [15:0] expSum, input logic expCout,
                                 input logic expOvf, input int expLat);
        int lat;
        mode = m; sat = s; dataa = a; datab = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = m ^ 2'b01;
        dataa = 16'($urandom);
        datab = 16'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            checkOutput({name, " hold"}, {16'h0, sum}, {16'h0, prevSum});
            checkOutput({name, " busy"}, {30'h0, ready, busy}, 32'h1);
            @(posedge clk); #1;
            lat++;
            if (glitch && lat == 2) begin
                start = 1'b1;
                mode  = 2'b10;
                datab = 16'd999;
            end else begin
                start = 1'b0;
            end
        end
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " sum"}, {16'h0, sum}, {16'h0, expSum});
        checkOutput({name, " carry/ovf"}, {30'h0, carry_out, overflow}, {30'h0, expCout, expOvf});
        @(posedge clk); #1;
        checkOutput({name, " ready after"}, {30'h0, ready, done}, 32'h2);
        prevSum = expSum;
    endtask

    initial begin
        int lat;
        vecs[0] = '{"add 6+10",        2'b00, 1'b0, 16'd6,     16'd10,    16'd16,    1'b0, 1'b0};
        vecs[1] = '{"add ffff+1 wrap", 2'b00, 1'b0, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b1};
        vecs[2] = '{"add ffff+1 sat",  2'b00, 1'b1, 16'hFFFF,  16'h0001,  16'hFFFF,  1'b1, 1'b1};
        vecs[3] = '{"sub 10-6",        2'b01, 1'b0, 16'd10,    16'd6,     16'd4,     1'b1, 1'b0};
        vecs[4] = '{"sub 6-10 wrap",   2'b01, 1'b0, 16'd6,     16'd10,    16'hFFFC,  1'b0, 1'b1};
        vecs[5] = '{"sub 6-10 sat",    2'b01, 1'b1, 16'd6,     16'd10,    16'h0000,  1'b0, 1'b1};
        vecs[6] = '{"sub 5-5",         2'b01, 1'b1, 16'd5,     16'd5,     16'h0000,  1'b1, 1'b0};
        vecs[7] = '{"add chain carry", 2'b00, 1'b0, 16'h0FFF,  16'h0001,  16'h1000,  1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; mode = 2'b00; sat = 1'b0; dataa = '0; datab = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready/busy/done", {29'h0, ready, busy, done}, 32'h4);
        checkOutput("reset sum/cout/ovf", {14'h0, sum, carry_out, overflow}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b, 1'b0,
                          vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf, 5);
        end

        // Back-to-back adds with start held high throughout.
        mode = 2'b00; sat = 1'b0; dataa = 16'd120; datab = 16'd200; start = 1'b1;
        @(posedge clk); #1;
        dataa = 16'd150;
        lat = 1;
        while (!done && lat < 20) begin
            checkOutput("b2b first hold", {16'h0, sum}, {16'h0, prevSum});
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("b2b first latency", lat, 5);
        checkOutput("b2b first sum", {16'h0, sum}, 32'h0140);
        @(posedge clk); #1;
        checkOutput("b2b idle ready", {31'h0, ready}, 32'h1);
        @(posedge clk); #1;
        lat = 1;
        while (!done && lat < 20) begin
            checkOutput("b2b second hold", {16'h0, sum}, 32'h0140);
            checkOutput("b2b second ready", {31'h0, ready}, 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checkOutput("b2b second latency", lat, 5);
        checkOutput("b2b second sum", {16'h0, sum}, 32'h015E);
        @(posedge clk); #1;
        checkOutput("b2b end ready", {31'h0, ready}, 32'h1);
        prevSum = 16'h015E;

        applyStimulus("clear",        2'b11, 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
        applyStimulus("acc 150",      2'b10, 1'b0, 16'h5555, 16'd150,  1'b0, 16'd150,  1'b0, 1'b0, 5);
        applyStimulus("acc 200 glitch", 2'b10, 1'b0, 16'h5555, 16'd200, 1'b1, 16'd350, 1'b0, 1'b0, 5);
        applyStimulus("acc ffff sat", 2'b10, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b1, 5);
        applyStimulus("acc +1 wrap",  2'b10, 1'b0, 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 5);
        applyStimulus("acc 7",        2'b10, 1'b0, 16'h0000, 16'd7,    1'b0, 16'd7,    1'b0, 1'b0, 5);

        // Reset in the second RUN cycle aborts the op and clears acc.
        mode = 2'b00; sat = 1'b0; dataa = 16'h1234; datab = 16'h1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort ready/busy/done", {29'h0, ready, busy, done}, 32'h4);
        checkOutput("abort sum/cout/ovf", {14'h0, sum, carry_out, overflow}, 32'h0);
        repeat (6) begin
            @(posedge clk); #1;
            checkOutput("abort no done", {30'h0, done, ready}, 32'h1);
        end
        prevSum = 16'h0000;
        applyStimulus("acc after abort", 2'b10, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 5);
        applyStimulus("add after abort", 2'b00, 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
